// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential shift-and-add multiplier.
package mult_pkg;
    localparam int WIDTH     = 8;
    localparam int PWIDTH    = 2 * WIDTH;
    localparam int STEP_LAST = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/add16_unit.sv
// Combinational two's-complement add/subtract shared by the multiply sequencer.
module add16_unit
    import mult_pkg::*;
(
    input  logic [PWIDTH-1:0] a,
    input  logic [PWIDTH-1:0] b,
    input  logic              sub,
    output logic [PWIDTH-1:0] sum,
    output logic              cout
);
    logic [PWIDTH-1:0] b_eff;

    // Subtraction is a + ~b + 1; the +1 comes in as carry-in.
    assign b_eff = b ^ {PWIDTH{sub}};
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{PWIDTH{1'b0}}, sub};
endmodule

// File: rtl/seq_mult_ctrl.sv
// 8x8 unsigned/signed multiplier: eight shift-and-accumulate steps through one
// shared add16_unit, with a registered start/busy/done handshake.
module seq_mult_ctrl
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [PWIDTH-1:0] product
);
    // Handshake: start is accepted when the controller is IDLE, or in the DONE
    // cycle so back-to-back operations run every 9 cycles; busy is high from the
    // edge after acceptance until the FSM returns to IDLE; done pulses for one
    // cycle exactly when product takes its new value. Starts during RUN are dropped.
    state_t state, state_next;

    logic [WIDTH-1:0]  a_reg, b_reg;
    logic              mode_reg;
    logic [PWIDTH-1:0] acc;
    logic [2:0]        count;

    logic [PWIDTH-1:0] ext, operand, sum, acc_next;
    logic              last_step, do_sub, load, add_cout_unused;

    assign ext       = mode_reg ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg}
                                : {{WIDTH{1'b0}}, a_reg};
    assign operand   = ext << count;
    assign last_step = (count == 3'(STEP_LAST));
    // The multiplier's top bit carries weight -2^7 in signed mode.
    assign do_sub    = mode_reg && last_step;
    assign acc_next  = b_reg[count] ? sum : acc;

    add16_unit u_add (
        .a    (acc),
        .b    (operand),
        .sub  (do_sub),
        .sum  (sum),
        .cout (add_cout_unused)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (last_step) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            mode_reg <= 1'b0;
            acc      <= '0;
            count    <= '0;
            product  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state == RUN) && last_step;
            if (load) begin
                a_reg    <= a;
                b_reg    <= b;
                mode_reg <= signed_mode;
                acc      <= '0;
                count    <= '0;
            end else if (state == RUN) begin
                acc   <= acc_next;
                count <= count + 3'd1;
                if (last_step) product <= acc_next;
            end
        end
    end
endmodule
